// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: one word per Valid/Ready handshake, framed as
// start, DATA_BITS data (LSB first), optional parity, STOP_BITS stop bits.
module uart_tx_frame #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1,
  parameter int unsigned CLK_DIV   = 16
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 Abort,
  input  logic [DATA_BITS-1:0] Data,
  input  logic                 Valid,
  output logic                 Ready,
  output logic                 Tx,
  output logic                 Busy,
  output logic                 Done
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state, state_nxt;
  logic [DIV_W-1:0]     div_cnt, div_nxt;
  logic [CNT_W-1:0]     bit_cnt, bit_nxt;
  logic [DATA_BITS-1:0] shreg, sh_nxt;
  logic                 par_bit, par_nxt;
  logic                 tx_nxt, ready_nxt, busy_nxt, done_nxt;
  logic                 bit_end;

  // State and registered outputs
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= S_IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      Tx      <= 1'b1;
      Ready   <= 1'b1;
      Busy    <= 1'b0;
      Done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      div_cnt <= div_nxt;
      bit_cnt <= bit_nxt;
      shreg   <= sh_nxt;
      par_bit <= par_nxt;
      Tx      <= tx_nxt;
      Ready   <= ready_nxt;
      Busy    <= busy_nxt;
      Done    <= done_nxt;
    end
  end

  // Next state; Tx is computed one cycle ahead so it flips exactly on bit boundaries
  always_comb begin
    state_nxt = state;
    div_nxt   = div_cnt;
    bit_nxt   = bit_cnt;
    sh_nxt    = shreg;
    par_nxt   = par_bit;
    tx_nxt    = Tx;
    bit_end   = (div_cnt == DIV_W'(CLK_DIV - 1));

    if (Abort) begin
      state_nxt = S_IDLE;
      div_nxt   = '0;
      bit_nxt   = '0;
      tx_nxt    = 1'b1;
    end else if (state == S_IDLE) begin
      if (Valid) begin
        state_nxt = S_START;
        sh_nxt    = Data;
        par_nxt   = (PARITY == 1) ? ~(^Data) : (^Data);
        div_nxt   = '0;
        bit_nxt   = '0;
        tx_nxt    = 1'b0;
      end
    end else if (!bit_end) begin
      div_nxt = div_cnt + DIV_W'(1);
    end else begin
      div_nxt = '0;
      case (state)
        S_START: begin
          state_nxt = S_DATA;
          bit_nxt   = '0;
          tx_nxt    = shreg[0];
        end
        S_DATA: begin
          if (bit_cnt == CNT_W'(DATA_BITS - 1)) begin
            bit_nxt = '0;
            if (PARITY != 0) begin
              state_nxt = S_PARITY;
              tx_nxt    = par_bit;
            end else begin
              state_nxt = S_STOP;
              tx_nxt    = 1'b1;
            end
          end else begin
            bit_nxt = bit_cnt + CNT_W'(1);
            sh_nxt  = {1'b0, shreg[DATA_BITS-1:1]};
            tx_nxt  = shreg[1];
          end
        end
        S_PARITY: begin
          state_nxt = S_STOP;
          bit_nxt   = '0;
          tx_nxt    = 1'b1;
        end
        S_STOP: begin
          tx_nxt = 1'b1;
          if (bit_cnt == CNT_W'(STOP_BITS - 1)) begin
            state_nxt = S_IDLE;
            bit_nxt   = '0;
          end else begin
            bit_nxt = bit_cnt + CNT_W'(1);
          end
        end
        default: begin
          state_nxt = S_IDLE;
        end
      endcase
    end

    ready_nxt = (state_nxt == S_IDLE);
    busy_nxt  = (state_nxt != S_IDLE);
    done_nxt  = (state_nxt == S_STOP) && (bit_nxt == CNT_W'(STOP_BITS - 1)) &&
                (div_nxt == DIV_W'(CLK_DIV - 1));
  end

endmodule
